wildcard_classifier: RTL and testbench
======================================

// Module: wildcard_classifier
// PURPOSE
//  Parametrised, programmable successor to the fixed casex-style decoder. It holds
//  RULES value/care pairs; a care bit of 0 is a don't-care. It classifies a
//  valid/ready input stream to the lowest-index matching rule, or to the default
//  class. The block is a 2-stage pipelined classifier between an upstream producer
//  and a downstream consumer. The rule table is rewritten at run time through a
//  config write port.
// PARAMETERS
//  WIDTH  3  data / rule width in bits
//  RULES  4  number of rules (>=1); class RULES is the default class
//  CW     $clog2(RULES+1)  class index width (derived; do not override)
//  IW     (RULES>1) ? $clog2(RULES) : 1  config index width (derived; do not override)
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  cfg_we      in   1      rule write strobe
//  cfg_idx     in   IW     rule index to write
//  cfg_value   in   WIDTH  rule compare value
//  cfg_care    in   WIDTH  rule care mask (1 = compare bit, 0 = don't care)
//  cfg_en      in   1      rule enable written with rule
//  in_valid    in   1      input beat valid
//  in_ready    out  1      block can accept input beat
//  in_data     in   WIDTH  data to classify
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer accepts result
//  out_class   out  CW     winning rule index, or RULES if no match
//  out_hit     out  1      1 = some enabled rule matched; 0 = default class
//  out_data    out  WIDTH  classified data, passed through
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//      all rules: en=0, value=0, care=0.
//      Both stage valids = 0.
//      out_valid=0, out_class=0, out_hit=0, out_data=0.
//      in_ready=1 once stage 1 is empty (combinational).
//  - Reset asserted mid-stream flushes all in-flight beats with no output.
//  - Match rule i: en[i] && (((d ^ value[i]) & care[i]) == 0).
//      Lowest i wins. care=0 with en=1 matches everything.
//  - Pipeline:
//      s2_ready = !out_valid | out_ready
//      s1_ready = !s1_valid | s2_ready
//      in_ready = s1_ready
//  - Stage 1 registers in_data on in_valid & in_ready.
//  - Stage 2 evaluates the rules on s1 data on the s1->s2 transfer and registers
//    class/hit/data.
//  - Latency: 2 cycles from accept to out_valid with out_ready held 1.
//    Throughput: 1 beat/cycle.
//  - Backpressure: outputs hold stable while out_valid & !out_ready.
//    At most 2 beats in flight. Order is preserved, with no drop or duplication.
//  - Config write takes effect the cycle after cfg_we. A classification on the same
//    edge as a write uses the pre-write table.
//  - cfg_idx >= RULES is ignored, with no table change.
// CONFIGURATION
//  STATS_EN defined:
//   - adds ports stat_clr (in, 1), stat_sel (in, CW) and stat_count (out, 16).
//   - RULES+1 saturating 16-bit counters (index RULES = default class).
//   - A counter increments on each out_valid & out_ready for its class.
//   - A counter holds at 16'hFFFF.
//   - stat_clr (sync) zeroes all counters; clear wins over a simultaneous increment.
//   - stat_count = counter[stat_sel] (combinational); 0 if stat_sel > RULES.
//   - Counters reset to 0.
//  STATS_EN undefined: no counters and no stat_* ports; datapath identical.
// TESTING (WIDTH=3, RULES=3)
//  1. Program r0 = val 000 care 100, r1 = val 100 care 110, r2 = val 111 care 111
//     (all en); stream 001, 101, 110, 111 with out_ready=1
//     -> (class,hit) = (0,1), (1,1), (3,0), (2,1); each result 2 cycles after accept.
//  2. Priority: r0 = care 000 en, others as in 1; input 111 -> class 0, hit 1.
//     Clear r0 en; input 111 -> class 2.
//  3. Backpressure: out_ready=0, offer 3 beats -> 2 accepted, then in_ready=0.
//     Release out_ready -> results emerge in order with values unchanged while stalled.
//  4. Same-edge cfg write r1 en=0 with s1->s2 transfer of 101 -> class 1.
//     Next 101 -> class 3, hit 0.
//  5. Assert rst_n mid-stream with 2 beats in flight -> out_valid=0 immediately.
//     Table cleared; after release any input -> class 3, hit 0.
//  6. STATS_EN: 3 hits on r1, read stat_sel=1 -> 3.
//     Then pulse stat_clr -> 0. Force 70000 default hits -> stat_sel=3 reads FFFF.

Source files
------------

// File: rtl/wildcard_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wildcard_classifier
// Description : Programmable wildcard classifier. Holds RULES value/care/enable
//               triples (care bit 0 = don't care) and assigns each beat of a
//               valid/ready stream to the lowest-index matching enabled rule,
//               or to the default class RULES when nothing matches.
//               Two register stages: stage 1 captures the input beat, stage 2
//               evaluates the rule table and holds the result.
// Optional    : STATS_EN - per-class saturating 16-bit result counters with
//               stat_clr / stat_sel / stat_count ports.
// Ports       :
//   clk, rst_n                     clock, asynchronous active-low reset
//   cfg_we/idx/value/care/en       rule table write port (idx >= RULES ignored)
//   in_valid / in_ready / in_data  upstream beat handshake
//   out_valid / out_ready          downstream result handshake
//   out_class / out_hit / out_data result: winning rule (or RULES), hit flag,
//                                  data passed through
//   stat_clr / stat_sel / stat_count  (STATS_EN only) counter clear/select/read
// Revision    : 1.0 - initial release
// ============================================================================
module wildcard_classifier #(
    parameter int WIDTH = 3,
    parameter int RULES = 4,
    parameter int CW    = $clog2(RULES + 1),
    parameter int IW    = (RULES > 1) ? $clog2(RULES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [WIDTH-1:0] cfg_value,
    input  logic [WIDTH-1:0] cfg_care,
    input  logic             cfg_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_class,
    output logic             out_hit,
    output logic [WIDTH-1:0] out_data
`ifdef STATS_EN
    ,
    input  logic             stat_clr,
    input  logic [CW-1:0]    stat_sel,
    output logic [15:0]      stat_count
`endif
);

    localparam logic [CW-1:0] C_DEFAULT_CLASS = CW'(RULES);

    // ------------------------------------------------------------------
    // Rule table
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_val  [RULES];
    logic [WIDTH-1:0] r_care [RULES];
    logic             r_en   [RULES];

    // Indices outside 0..RULES-1 match no loop iteration, so such writes
    // leave the table untouched without a separate range check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RULES; i++) begin
                r_val[i]  <= '0;
                r_care[i] <= '0;
                r_en[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < RULES; i++) begin
                if (cfg_we && (cfg_idx == IW'(i))) begin
                    r_val[i]  <= cfg_value;
                    r_care[i] <= cfg_care;
                    r_en[i]   <= cfg_en;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline handshake
    // ------------------------------------------------------------------
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_out_valid;
    logic [CW-1:0]    r_out_class;
    logic             r_out_hit;
    logic [WIDTH-1:0] r_out_data;

    logic w_s2_ready;
    logic w_s1_ready;
    logic w_in_fire;
    logic w_s1_to_s2;
    logic w_out_fire;

    assign w_s2_ready = !r_out_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_in_fire  = in_valid && w_s1_ready;
    assign w_s1_to_s2 = r_s1_valid && w_s2_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // ------------------------------------------------------------------
    // Rule evaluation on stage-1 data. Scanning from the highest index
    // down lets the lowest matching rule overwrite any later match.
    // ------------------------------------------------------------------
    logic [CW-1:0] w_class;
    logic          w_hit;

    always_comb begin
        w_class = C_DEFAULT_CLASS;
        w_hit   = 1'b0;
        for (int i = RULES - 1; i >= 0; i--) begin
            if (r_en[i] && (((r_s1_data ^ r_val[i]) & r_care[i]) == '0)) begin
                w_class = CW'(i);
                w_hit   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture incoming beat
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: register classification result. Holds while stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_hit   <= 1'b0;
            r_out_data  <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (w_s1_to_s2) begin
                r_out_class <= w_class;
                r_out_hit   <= w_hit;
                r_out_data  <= r_s1_data;
            end
        end
    end

    assign in_ready  = w_s1_ready;
    assign out_valid = r_out_valid;
    assign out_class = r_out_class;
    assign out_hit   = r_out_hit;
    assign out_data  = r_out_data;

`ifdef STATS_EN
    // ------------------------------------------------------------------
    // Per-class saturating result counters (index RULES = default class)
    // ------------------------------------------------------------------
    logic [15:0] r_cnt [RULES + 1];
    logic [15:0] w_stat_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= RULES; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (stat_clr) begin
            // Clear takes priority over an increment on the same edge.
            for (int i = 0; i <= RULES; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_out_fire) begin
            for (int i = 0; i <= RULES; i++) begin
                if ((r_out_class == CW'(i)) && (r_cnt[i] != 16'hFFFF)) begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Selecting through a compare loop returns 0 for any stat_sel > RULES.
    always_comb begin
        w_stat_count = '0;
        for (int i = 0; i <= RULES; i++) begin
            if (stat_sel == CW'(i)) begin
                w_stat_count = r_cnt[i];
            end
        end
    end

    assign stat_count = w_stat_count;
`else
    // Handshake completion only feeds the counters.
    logic w_unused;
    assign w_unused = w_out_fire;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wildcard_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wildcard_classifier
// Description : Self-checking bench for wildcard_classifier (WIDTH=3, RULES=3)
//               with a behavioural rule-table model and result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wildcard_classifier;

    localparam int WIDTH = 3;
    localparam int RULES = 3;
    localparam int CW    = $clog2(RULES + 1);
    localparam int IW    = (RULES > 1) ? $clog2(RULES) : 1;
    localparam int RW    = CW + 1 + WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic [IW-1:0]    cfg_idx;
    logic [WIDTH-1:0] cfg_value;
    logic [WIDTH-1:0] cfg_care;
    logic             cfg_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_class;
    logic             out_hit;
    logic [WIDTH-1:0] out_data;
`ifdef STATS_EN
    logic             stat_clr;
    logic [CW-1:0]    stat_sel;
    logic [15:0]      stat_count;
`endif

    wildcard_classifier #(.WIDTH(WIDTH), .RULES(RULES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_value (cfg_value),
        .cfg_care  (cfg_care),
        .cfg_en    (cfg_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_hit   (out_hit),
        .out_data  (out_data)
`ifdef STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_sel  (stat_sel),
        .stat_count(stat_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural rule table
    logic [WIDTH-1:0] m_val  [RULES];
    logic [WIDTH-1:0] m_care [RULES];
    logic             m_en   [RULES];

    // Outputs captured by the last cycle() call, just before its rising edge
    logic             s_valid;
    logic             s_ready;
    logic [CW-1:0]    s_class;
    logic             s_hit;
    logic [WIDTH-1:0] s_data;

    function automatic int ref_class(input logic [WIDTH-1:0] d);
        for (int i = 0; i < RULES; i++) begin
            if (m_en[i] && (((d ^ m_val[i]) & m_care[i]) == '0)) return i;
        end
        return RULES;
    endfunction

    function automatic logic [RW-1:0] ref_result(input logic [WIDTH-1:0] d);
        int c;
        c = ref_class(d);
        return {CW'(c), (c != RULES), d};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < RULES; i++) begin
            m_val[i] = '0; m_care[i] = '0; m_en[i] = 1'b0;
        end
    endtask

    // One clock cycle, starting and ending on a falling edge.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                         output logic acc, output logic emit);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        s_valid = out_valid; s_ready = in_ready;
        s_class = out_class; s_hit = out_hit; s_data = out_data;
        acc  = iv & in_ready;
        emit = out_valid & ordy;
        @(negedge clk);
    endtask

    task automatic cfg_write(input int idx, input logic [WIDTH-1:0] v,
                             input logic [WIDTH-1:0] c, input logic e);
        in_valid = 1'b0; out_ready = 1'b1;
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_value = v; cfg_care = c; cfg_en = e;
        @(negedge clk);
        cfg_we = 1'b0;
        if (idx < RULES) begin
            m_val[idx] = v; m_care[idx] = c; m_en[idx] = e;
        end
    endtask

    task automatic program_t1();
        cfg_write(0, 3'b000, 3'b100, 1'b1);
        cfg_write(1, 3'b100, 3'b110, 1'b1);
        cfg_write(2, 3'b111, 3'b111, 1'b1);
    endtask

    // Offers one beat to an empty pipeline and waits (bounded) for its result.
    task automatic classify_one(input logic [WIDTH-1:0] d, output logic [CW-1:0] c,
                                output logic h, output logic [WIDTH-1:0] o, output int lat);
        logic acc, emit;
        lat = -1; c = '0; h = 1'b0; o = '0;
        for (int n = 0; n < 8; n++) begin
            cycle(n == 0, d, 1'b1, acc, emit);
            if (emit) begin
                c = s_class; h = s_hit; o = s_data; lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_value = '0; cfg_care = '0;
        cfg_en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef STATS_EN
        stat_clr = 1'b0; stat_sel = '0;
`endif
        model_clear();
        @(negedge clk); @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%b exp=0", out_valid); end
        total++; if (out_class !== '0) begin bad++; $display("FAIL reset_out_class: got=%0d exp=0", out_class); end
        total++; if (out_hit !== 1'b0) begin bad++; $display("FAIL reset_out_hit: got=%b exp=0", out_hit); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got=%0h exp=0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_stream();
        logic [WIDTH-1:0] din  [4] = '{3'b001, 3'b101, 3'b110, 3'b111};
        logic [CW-1:0]    ecls [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
        logic             ehit [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int acc_cyc [4];
        int na = 0, ne = 0;
        logic acc, emit;
        program_t1();
        for (int n = 0; n < 8; n++) begin
            cycle(n < 4, (n < 4) ? din[n] : 3'b000, 1'b1, acc, emit);
            if (n < 4) begin
                total++; if (acc !== 1'b1) begin bad++; $display("FAIL basic_accept%0d: got=%b exp=1", n, acc); end
            end
            if (emit) begin
                if (ne < 4) begin
                    total++; if (s_class !== ecls[ne] || s_hit !== ehit[ne] || s_data !== din[ne]) begin
                        bad++; $display("FAIL basic_result%0d: got=(%0d,%b,%0h) exp=(%0d,%b,%0h)",
                                        ne, s_class, s_hit, s_data, ecls[ne], ehit[ne], din[ne]);
                    end
                    total++; if (n !== acc_cyc[ne] + 2) begin
                        bad++; $display("FAIL basic_latency%0d: got=%0d exp=2", ne, n - acc_cyc[ne]);
                    end
                end
                ne++;
            end
            if (acc && na < 4) begin acc_cyc[na] = n; na++; end
        end
        total++; if (ne !== 4) begin bad++; $display("FAIL basic_count: got=%0d exp=4", ne); end
    endtask

    task automatic test_priority();
        logic [CW-1:0] c; logic h; logic [WIDTH-1:0] o; int lat;
        cfg_write(0, 3'b000, 3'b000, 1'b1);
        classify_one(3'b111, c, h, o, lat);
        total++; if (c !== 2'd0 || h !== 1'b1 || lat !== 2) begin
            bad++; $display("FAIL prio_r0_all: got=(%0d,%b,lat%0d) exp=(0,1,lat2)", c, h, lat);
        end
        cfg_write(0, 3'b000, 3'b000, 1'b0);
        classify_one(3'b111, c, h, o, lat);
        total++; if (c !== 2'd2 || h !== 1'b1 || o !== 3'b111) begin
            bad++; $display("FAIL prio_r0_off: got=(%0d,%b,%0h) exp=(2,1,7)", c, h, o);
        end
    endtask

    task automatic test_backpressure();
        logic acc, emit;
        program_t1();
        cycle(1'b1, 3'b001, 1'b0, acc, emit);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_accept0: got=%b exp=1", acc); end
        cycle(1'b1, 3'b110, 1'b0, acc, emit);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_accept1: got=%b exp=1", acc); end
        for (int n = 0; n < 4; n++) begin
            cycle(1'b1, 3'b111, 1'b0, acc, emit);
            total++; if (acc !== 1'b0 || s_ready !== 1'b0) begin
                bad++; $display("FAIL bp_full%0d: got in_ready=%b exp=0", n, s_ready);
            end
            total++; if (s_valid !== 1'b1 || s_class !== 2'd0 || s_hit !== 1'b1 || s_data !== 3'b001) begin
                bad++; $display("FAIL bp_hold%0d: got=(%b,%0d,%b,%0h) exp=(1,0,1,1)", n, s_valid, s_class, s_hit, s_data);
            end
        end
        cycle(1'b0, 3'b000, 1'b1, acc, emit);
        total++; if (emit !== 1'b1 || s_class !== 2'd0 || s_data !== 3'b001) begin
            bad++; $display("FAIL bp_release0: got=(%b,%0d,%0h) exp=(1,0,1)", emit, s_class, s_data);
        end
        cycle(1'b0, 3'b000, 1'b1, acc, emit);
        total++; if (emit !== 1'b1 || s_class !== 2'd3 || s_hit !== 1'b0 || s_data !== 3'b110) begin
            bad++; $display("FAIL bp_release1: got=(%b,%0d,%b,%0h) exp=(1,3,0,6)", emit, s_class, s_hit, s_data);
        end
        cycle(1'b0, 3'b000, 1'b1, acc, emit);
        total++; if (emit !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got=%b exp=0", emit); end
    endtask

    task automatic test_same_edge_cfg();
        logic acc, emit;
        logic [CW-1:0] c; logic h; logic [WIDTH-1:0] o; int lat;
        program_t1();
        cycle(1'b1, 3'b101, 1'b1, acc, emit);
        // 101 moves s1->s2 on the same edge that disables r1
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_value = 3'b100; cfg_care = 3'b110; cfg_en = 1'b0;
        cycle(1'b0, 3'b000, 1'b1, acc, emit);
        cfg_we = 1'b0; m_en[1] = 1'b0;
        cycle(1'b0, 3'b000, 1'b1, acc, emit);
        total++; if (emit !== 1'b1 || s_class !== 2'd1 || s_hit !== 1'b1) begin
            bad++; $display("FAIL same_edge_prewrite: got=(%b,%0d,%b) exp=(1,1,1)", emit, s_class, s_hit);
        end
        classify_one(3'b101, c, h, o, lat);
        total++; if (c !== 2'd3 || h !== 1'b0) begin
            bad++; $display("FAIL same_edge_postwrite: got=(%0d,%b) exp=(3,0)", c, h);
        end
        // Out-of-range index: must not alter any rule
        cfg_write(3, 3'b000, 3'b000, 1'b1);
        classify_one(3'b101, c, h, o, lat);
        total++; if (c !== 2'd3 || h !== 1'b0) begin
            bad++; $display("FAIL idx_out_of_range: got=(%0d,%b) exp=(3,0)", c, h);
        end
    endtask

    task automatic test_reset_midstream();
        logic acc, emit;
        logic [CW-1:0] c; logic h; logic [WIDTH-1:0] o; int lat;
        cfg_write(0, 3'b000, 3'b000, 1'b1);
        cycle(1'b1, 3'b010, 1'b0, acc, emit);
        cycle(1'b1, 3'b011, 1'b0, acc, emit);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_flush: got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        classify_one(3'b100, c, h, o, lat);
        total++; if (c !== 2'd3 || h !== 1'b0 || o !== 3'b100 || lat !== 2) begin
            bad++; $display("FAIL midreset_after: got=(%0d,%b,%0h,lat%0d) exp=(3,0,4,lat2)", c, h, o, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, emit;
        logic [WIDTH-1:0] din [10];
        int ne = 0;
        logic [RW-1:0] exp_r;
        cfg_write(0, 3'b010, 3'b011, 1'b1);
        cfg_write(1, 3'b001, 3'b001, 1'b1);
        cfg_write(2, 3'b100, 3'b100, 1'b1);
        for (int i = 0; i < 10; i++) din[i] = WIDTH'($urandom);
        for (int n = 0; n < 12; n++) begin
            cycle(n < 10, (n < 10) ? din[n] : 3'b000, 1'b1, acc, emit);
            if (n < 10) begin
                total++; if (acc !== 1'b1) begin bad++; $display("FAIL b2b_accept%0d: got=%b exp=1", n, acc); end
            end
            if (n >= 2) begin
                exp_r = ref_result(din[n - 2]);
                total++; if (emit !== 1'b1 || {s_class, s_hit, s_data} !== exp_r) begin
                    bad++; $display("FAIL b2b_result%0d: got=(%b,%0h) exp=(1,%0h)", n - 2, emit, {s_class, s_hit, s_data}, exp_r);
                end
                ne++;
            end
        end
    endtask

    task automatic test_random();
        logic acc, emit, iv, ordy;
        logic [WIDTH-1:0] d;
        logic [RW-1:0] exp_q [$];
        logic [RW-1:0] got, prev;
        logic prev_stall;
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < RULES; i++) begin
                cfg_write(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            end
            prev_stall = 1'b0; prev = '0;
            for (int n = 0; n < 300; n++) begin
                iv   = 1'($urandom);
                ordy = ($urandom_range(0, 3) != 0);
                d    = WIDTH'($urandom);
                cycle(iv, d, ordy, acc, emit);
                got = {s_class, s_hit, s_data};
                if (prev_stall) begin
                    total++; if (s_valid !== 1'b1 || got !== prev) begin
                        bad++; $display("FAIL rnd_stall_hold r%0d n%0d: got=(%b,%0h) exp=(1,%0h)", round, n, s_valid, got, prev);
                    end
                end
                prev_stall = s_valid & ~ordy;
                prev = got;
                if (emit) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++; $display("FAIL rnd_spurious r%0d n%0d: got=%0h exp=none", round, n, got);
                    end else begin
                        total++; if (got !== exp_q[0]) begin
                            bad++; $display("FAIL rnd_result r%0d n%0d: got=%0h exp=%0h", round, n, got, exp_q[0]);
                        end
                        void'(exp_q.pop_front());
                    end
                end
                if (acc) exp_q.push_back(ref_result(d));
                if (exp_q.size() > 2) begin
                    total++; bad++; $display("FAIL rnd_inflight r%0d n%0d: got=%0d exp<=2", round, n, exp_q.size());
                    exp_q.delete();
                end
            end
            for (int n = 0; n < 6 && exp_q.size() != 0; n++) begin
                cycle(1'b0, 3'b000, 1'b1, acc, emit);
                if (emit) begin
                    got = {s_class, s_hit, s_data};
                    total++; if (got !== exp_q[0]) begin
                        bad++; $display("FAIL rnd_drain r%0d: got=%0h exp=%0h", round, got, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            total++; if (exp_q.size() != 0) begin
                bad++; $display("FAIL rnd_drain_timeout r%0d: got=%0d left exp=0", round, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

`ifdef STATS_EN
    task automatic test_stats();
        logic acc, emit;
        logic [CW-1:0] c; logic h; logic [WIDTH-1:0] o; int lat;
        stat_clr = 1'b1; @(negedge clk); stat_clr = 1'b0;
        program_t1();
        for (int i = 0; i < 3; i++) classify_one(3'b101, c, h, o, lat);
        stat_sel = 2'd1; #1;
        total++; if (stat_count !== 16'd3) begin bad++; $display("FAIL stat_r1_count: got=%0d exp=3", stat_count); end
        @(negedge clk);
        stat_clr = 1'b1; @(negedge clk); stat_clr = 1'b0; #1;
        total++; if (stat_count !== 16'd0) begin bad++; $display("FAIL stat_clear: got=%0d exp=0", stat_count); end
        @(negedge clk);
        for (int i = 0; i < RULES; i++) cfg_write(i, 3'b000, 3'b000, 1'b0);
        for (int n = 0; n < 70004; n++) cycle(n < 70000, WIDTH'($urandom), 1'b1, acc, emit);
        stat_sel = 2'd3; #1;
        total++; if (stat_count !== 16'hFFFF) begin bad++; $display("FAIL stat_saturate: got=%0h exp=ffff", stat_count); end
        stat_sel = 2'd1; #1;
        total++; if (stat_count !== 16'd0) begin bad++; $display("FAIL stat_other_class: got=%0d exp=0", stat_count); end
        @(negedge clk);
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_stream();
        test_priority();
        test_backpressure();
        test_same_edge_cfg();
        test_reset_midstream();
        test_back_to_back();
        test_random();
`ifdef STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
